// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, schedule sigma functions,
// block geometry and the schedule-feed FSM state type.
package sha256_pkg;

    localparam int unsigned SHA_ROUNDS      = 64;
    localparam int unsigned SHA_BLOCK_WORDS = 16;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } sched_state_t;

    localparam logic [31:0] SHA_K [SHA_ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sigma0_w(input logic [31:0] x);
        return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1_w(input logic [31:0] x);
        return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/mod_w_sched_feed_if.sv
// Word-load handshake and round-stream bus of the schedule feeder.
interface mod_w_sched_feed_if;

    logic        WORD_VALID;
    logic [31:0] WORD_DATA;
    logic        WORD_READY;
    logic        STALL;
    logic        EN;
    logic [5:0]  I;
    logic [31:0] W_OUT;
    logic [31:0] K_OUT;
    logic        BUSY;
    logic        DONE;

    // Driver side: supplies message words and compressor back-pressure.
    modport master (
        output WORD_VALID, WORD_DATA, STALL,
        input  WORD_READY, EN, I, W_OUT, K_OUT, BUSY, DONE
    );

    // Feeder side.
    modport slave (
        input  WORD_VALID, WORD_DATA, STALL,
        output WORD_READY, EN, I, W_OUT, K_OUT, BUSY, DONE
    );

endinterface

// File: rtl/mod_w_sched_feed_k_rom.sv
// Combinational SHA-256 round-constant lookup, shared by the SHA blocks.
module mod_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0]  ADDR,
    output logic [31:0] K_VAL
);

    // Table lookup of K[ADDR].
    always_comb begin
        K_VAL = SHA_K[ADDR];
    end

endmodule

// File: rtl/mod_w_sched_feed.sv
// SHA-256 message-schedule feeder: loads 16 words, then streams one
// (I, W_t, K_t) round per unstalled cycle using a 16-word sliding window.
module mod_w_sched_feed
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS = SHA_ROUNDS
) (
    input  logic               CLK,
    input  logic               RESET_N,
    mod_w_sched_feed_if.slave  bus
);

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    sched_state_t state_q, state_d;

    logic [3:0]  load_cnt_q;
    logic [5:0]  t_q;
    logic [31:0] win_q [SHA_BLOCK_WORDS];

    logic        en_q;
    logic        done_q;
    logic [5:0]  i_q;
    logic [31:0] w_q;
    logic [31:0] k_q;

    logic        word_ready;
    logic        word_xfer;
    logic        advance;
    logic        busy;

    logic [3:0]  slot;
    logic [3:0]  slot_m2;
    logic [3:0]  slot_m7;
    logic [3:0]  slot_m15;
    logic [31:0] w_exp;
    logic [31:0] w_t;
    logic [31:0] k_t;

    mod_k_rom u_k_rom (
        .ADDR  (t_q),
        .K_VAL (k_t)
    );

    // Window taps for round t: slots wrap mod 16, read before this edge's write.
    always_comb begin
        slot     = t_q[3:0];
        slot_m2  = slot - 4'd2;
        slot_m7  = slot - 4'd7;
        slot_m15 = slot - 4'd15;
        w_exp    = sigma1_w(win_q[slot_m2]) + win_q[slot_m7]
                 + sigma0_w(win_q[slot_m15]) + win_q[slot];
        w_t      = (t_q[5:4] == 2'b00) ? win_q[slot] : w_exp;
    end

    // Next state and control strobes. The DONE cycle blocks word transfers
    // so the next load starts strictly after the pulse.
    always_comb begin
        state_d    = state_q;
        word_ready = 1'b0;
        word_xfer  = 1'b0;
        advance    = 1'b0;
        busy       = 1'b0;
        case (state_q)
            ST_LOAD: begin
                word_ready = !done_q;
                word_xfer  = word_ready && bus.WORD_VALID;
                if (word_xfer && (load_cnt_q == 4'd15)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy    = 1'b1;
                advance = !bus.STALL;
                if (advance && (t_q == LAST_T)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_LOAD;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Load counter and round index.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            load_cnt_q <= '0;
            t_q        <= '0;
        end else begin
            if (word_xfer) begin
                load_cnt_q <= load_cnt_q + 4'd1;
            end else if (state_q == ST_FIN) begin
                load_cnt_q <= '0;
            end
            if (advance) begin
                t_q <= t_q + 6'd1;
            end else if (state_q == ST_FIN) begin
                t_q <= '0;
            end
        end
    end

    // Registered round outputs; they hold while stalled.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            en_q   <= 1'b0;
            done_q <= 1'b0;
            i_q    <= '0;
            w_q    <= '0;
            k_q    <= '0;
        end else begin
            en_q   <= advance;
            done_q <= (state_q == ST_FIN);
            if (advance) begin
                i_q <= t_q;
                w_q <= w_t;
                k_q <= k_t;
            end
        end
    end

    // Window: one write per cycle, either a loaded word or the expanded W_t.
    always_ff @(posedge CLK) begin
        if (word_xfer) begin
            win_q[load_cnt_q] <= bus.WORD_DATA;
        end else if (advance && (t_q[5:4] != 2'b00)) begin
            win_q[slot] <= w_exp;
        end
    end

    assign bus.WORD_READY = word_ready;
    assign bus.EN         = en_q;
    assign bus.I          = i_q;
    assign bus.W_OUT      = w_q;
    assign bus.K_OUT      = k_q;
    assign bus.BUSY       = busy;
    assign bus.DONE       = done_q;

endmodule

// File: tb/tb_mod_w_sched_feed.sv
// Directed bench for mod_w_sched_feed with a behavioural compressor model.
module tb_mod_w_sched_feed;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mod_w_sched_feed_if bus ();

    mod_w_sched_feed #(.ROUNDS(64)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor (samples on falling edge) ----------------
    logic        mon_clr = 1'b0;
    int          cyc = 0;
    int          cap_n, done_n, done_gap, last_en_cyc, first_en_cyc, ready_in_run, hold_err;
    logic [5:0]  cap_i [64];
    logic [31:0] cap_w [64];
    logic [31:0] cap_k [64];
    logic [5:0]  prev_i;
    logic [31:0] prev_w, prev_k;
    logic        prev_rst = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (mon_clr) begin
            cap_n = 0; done_n = 0; done_gap = -1; last_en_cyc = -1;
            first_en_cyc = -1; ready_in_run = 0; hold_err = 0;
        end else begin
            if (bus.EN) begin
                if (cap_n < 64) begin
                    cap_i[cap_n] = bus.I;
                    cap_w[cap_n] = bus.W_OUT;
                    cap_k[cap_n] = bus.K_OUT;
                end
                if (first_en_cyc < 0) first_en_cyc = cyc;
                cap_n++;
                last_en_cyc = cyc;
            end
            if (bus.DONE) begin
                done_n++;
                done_gap = cyc - last_en_cyc;
            end
            if (bus.BUSY && bus.WORD_READY) ready_in_run++;
            if (!bus.EN && rst_n && prev_rst &&
                (bus.I != prev_i || bus.W_OUT != prev_w || bus.K_OUT != prev_k)) hold_err++;
        end
        prev_i = bus.I; prev_w = bus.W_OUT; prev_k = bus.K_OUT; prev_rst = rst_n;
    end

    // ---------------- reference models ----------------
    logic [31:0] exp_w [64];

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction
    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction
    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    task automatic build_exp(input logic [31:0] blk [16]);
        for (int t = 0; t < 64; t++) begin
            if (t < 16) exp_w[t] = blk[t];
            else exp_w[t] = ssig1(exp_w[t-2]) + exp_w[t-7] + ssig0(exp_w[t-15]) + exp_w[t-16];
        end
    endtask

    // Compressor fed with the captured EN-qualified rounds, H = SHA-256 IV.
    function automatic logic [255:0] compress_capture();
        logic [31:0] iv [8];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        iv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        a = iv[0]; b = iv[1]; c = iv[2]; d = iv[3];
        e = iv[4]; f = iv[5]; g = iv[6]; h = iv[7];
        for (int r = 0; r < 64; r++) begin
            t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + cap_k[r] + cap_w[r];
            t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + iv[0], b + iv[1], c + iv[2], d + iv[3],
                e + iv[4], f + iv[5], g + iv[6], h + iv[7]};
    endfunction

    // ---------------- stimulus tasks (drive at posedge + 1) ----------------
    task automatic mon_clear();
        mon_clr = 1'b1;
        @(posedge clk); #1;
        mon_clr = 1'b0;
    endtask

    task automatic load_block(input logic [31:0] blk [16], input bit gaps, output int end_cyc);
        int k = 0;
        int guard = 0;
        while (k < 16 && guard < 400) begin
            guard++;
            if (gaps && ($urandom_range(0, 1) == 0)) begin
                bus.WORD_VALID = 1'b0;
                bus.WORD_DATA  = 32'hdeadbeef;
            end else begin
                bus.WORD_VALID = 1'b1;
                bus.WORD_DATA  = blk[k];
                if (bus.WORD_READY) k++;
            end
            @(posedge clk); #1;
        end
        bus.WORD_VALID = 1'b0;
        end_cyc = cyc;
        check_val("load_guard", k, 16);
    endtask

    task automatic run_stream(input bit rnd_stall, input bit hold_valid);
        int guard = 0;
        if (hold_valid) begin
            bus.WORD_VALID = 1'b1;
            bus.WORD_DATA  = 32'ha5a55a5a;
        end
        while (!bus.DONE && guard < 1000) begin
            bus.STALL = rnd_stall ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
            guard++;
        end
        bus.STALL      = 1'b0;
        bus.WORD_VALID = 1'b0;
        check_val("done_guard", guard < 1000, 1);
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic verify_stream(input string name);
        check_val({name, "_en_count"}, cap_n, 64);
        for (int r = 0; r < 64; r++) begin
            check_val($sformatf("%s_i%0d", name, r), cap_i[r], r);
            check_val($sformatf("%s_w%0d", name, r), cap_w[r], exp_w[r]);
        end
        check_val({name, "_done_count"}, done_n, 1);
        check_val({name, "_done_gap"}, done_gap, 1);
        check_val({name, "_ready_in_run"}, ready_in_run, 0);
        check_val({name, "_stall_hold"}, hold_err, 0);
    endtask

    // ---------------- main sequence ----------------
    logic [31:0] blk_zero [16];
    logic [31:0] blk_bit  [16];
    logic [31:0] blk_hello[16];
    localparam logic [255:0] HELLO_HASH =
        256'hc0535e4b_e2b79ffd_93291305_436bf889_314e4a3f_aec05ecf_fcbb7df3_1ad9e51a;

    initial begin
        int end_cyc;
        int guard;

        for (int k = 0; k < 16; k++) begin
            blk_zero[k]  = '0;
            blk_bit[k]   = '0;
            blk_hello[k] = '0;
        end
        blk_bit[0]    = 32'h00000001;
        blk_hello[0]  = 32'h48656c6c;
        blk_hello[1]  = 32'h6f20776f;
        blk_hello[2]  = 32'h726c6421;
        blk_hello[3]  = 32'h80000000;
        blk_hello[15] = 32'h00000060;

        bus.WORD_VALID = 1'b0;
        bus.WORD_DATA  = '0;
        bus.STALL      = 1'b0;
        rst_n          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_en", bus.EN, 0);
        check_val("rst_i", bus.I, 0);
        check_val("rst_w", bus.W_OUT, 0);
        check_val("rst_k", bus.K_OUT, 0);
        check_val("rst_busy", bus.BUSY, 0);
        check_val("rst_done", bus.DONE, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("rst_ready", bus.WORD_READY, 1);

        // All-zero block, unstalled.
        mon_clear();
        build_exp(blk_zero);
        load_block(blk_zero, 1'b0, end_cyc);
        run_stream(1'b0, 1'b0);
        verify_stream("zero");
        check_val("zero_latency", first_en_cyc - end_cyc, 2);
        check_val("zero_k0", cap_k[0], 32'h428a2f98);
        check_val("zero_k1", cap_k[1], 32'h71374491);
        check_val("zero_k63", cap_k[63], 32'hc67178f2);

        // Single-bit block.
        mon_clear();
        build_exp(blk_bit);
        load_block(blk_bit, 1'b0, end_cyc);
        run_stream(1'b0, 1'b0);
        verify_stream("bit");
        check_val("bit_w16", cap_w[16], 32'h00000001);
        check_val("bit_w17", cap_w[17], 32'h00000000);
        check_val("bit_w18", cap_w[18], 32'h0000a000);

        // Hello block, gapped loading, unstalled run.
        mon_clear();
        build_exp(blk_hello);
        load_block(blk_hello, 1'b1, end_cyc);
        run_stream(1'b0, 1'b0);
        verify_stream("hello");
        check_val("hello_latency", first_en_cyc - end_cyc, 2);
        check_val("hello_hash", compress_capture(), HELLO_HASH);

        // Hello block, random stall, WORD_VALID held high during RUN.
        mon_clear();
        load_block(blk_hello, 1'b1, end_cyc);
        run_stream(1'b1, 1'b1);
        verify_stream("stall");
        check_val("stall_hash", compress_capture(), HELLO_HASH);

        // Reset at round 20, then a fresh block.
        mon_clear();
        load_block(blk_bit, 1'b0, end_cyc);
        guard = 0;
        while (!(bus.EN && bus.I == 6'd20) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check_val("mid_reach_r20", guard < 200, 1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_en", bus.EN, 0);
        check_val("mid_rst_i", bus.I, 0);
        check_val("mid_rst_w", bus.W_OUT, 0);
        check_val("mid_rst_k", bus.K_OUT, 0);
        check_val("mid_rst_busy", bus.BUSY, 0);
        check_val("mid_rst_done", bus.DONE, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("mid_ready", bus.WORD_READY, 1);
        mon_clear();
        load_block(blk_hello, 1'b0, end_cyc);
        run_stream(1'b0, 1'b0);
        verify_stream("after_rst");
        check_val("after_rst_first_w", cap_w[0], 32'h48656c6c);
        check_val("after_rst_hash", compress_capture(), HELLO_HASH);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
